pc_fetch_ctrl: RTL and testbench
================================

PC_FETCH_CTRL -- requirements
Module: pc_fetch_ctrl

Interface
REQ-001 SHALL have parameter RESET_VEC, default 32'h0000_0000, the first fetch address after reset.
REQ-002 SHALL have clk  input  1  the single clock; all state changes on its rising edge.
REQ-003 SHALL have rst_n  input  1  reset, asynchronous and active-low.
REQ-004 SHALL have branch_taken  input  1  redirect to branch target this cycle.
REQ-005 SHALL have jump  input  1  redirect to jump target this cycle.
REQ-006 SHALL have jr  input  1  redirect to register target this cycle.
REQ-007 SHALL have npc_sel  output  2  select to the external 4:1 next-PC mux; inputs a=pc_plus4, b=branch, c=jump, d=register target.
REQ-008 SHALL have pc_plus4  output  32  current PC + 4; drives mux input a.
REQ-009 SHALL have npc  input  32  next-PC value returned from the mux.
REQ-010 SHALL have imem_req  output  1  instruction-memory request, held until imem_ack.
REQ-011 SHALL have imem_addr  output  32  fetch address, equal to PC.
REQ-012 SHALL have imem_ack  input  1  one-cycle pulse; imem_rdata valid in the same cycle.
REQ-013 SHALL have imem_rdata  input  32  fetched instruction word.
REQ-014 SHALL have if_valid  output  1  if_instr and if_pc hold a valid instruction.
REQ-015 SHALL have if_instr  output  32  fetched instruction to decode.
REQ-016 SHALL have if_pc  output  32  address of if_instr.
REQ-017 SHALL have if_ready  input  1  decode accepts the instruction this cycle.

Function
REQ-018 SHALL drive npc_sel combinationally with priority jr=2'b11 > jump=2'b10 > branch_taken=2'b01 > sequential=2'b00; redirect = jr|jump|branch_taken.
REQ-019 SHALL compute pc_plus4 = PC + 4, modulo 2^32 (32'hFFFF_FFFC wraps to 32'h0).
REQ-020 SHALL force bits [1:0] of npc to 2'b00 on every PC load.
REQ-021 SHALL implement states BOOT, FETCH, VALID, DRAIN.
REQ-022 BOOT: imem_req=0, imem_ack ignored; always goes to FETCH next cycle.
REQ-023 FETCH: imem_req=1, imem_addr=PC.
- ack and no redirect: if_instr<=imem_rdata, if_pc<=PC, PC<=npc; go to VALID.
- ack and redirect: data discarded, PC<=npc; stay in FETCH with a new request next cycle.
- redirect and no ack: PC<=npc; go to DRAIN.
REQ-024 DRAIN: imem_req=0; a redirect loads PC<=npc (latest redirect wins); on imem_ack data discarded, go to FETCH.
REQ-025 VALID: if_valid=1.
- redirect: if_valid cleared next cycle (flush), PC<=npc, go to FETCH; takes priority over if_ready in the same cycle.
- if_ready and no redirect: go to FETCH.
- neither: hold all outputs.
REQ-026 SHALL issue the next request one cycle after acceptance; fetch-to-valid latency SHALL be exactly one cycle after imem_ack.
REQ-027 SHALL keep PC unchanged in any cycle with no redirect and no accepted imem_ack.

Reset
REQ-028 On rst_n low, all state SHALL clear immediately: state=BOOT, PC=RESET_VEC, imem_req=0, if_valid=0, if_instr=0, if_pc=0; pc_plus4 SHALL read RESET_VEC+4.
REQ-029 Reset mid-fetch SHALL abandon the outstanding request; instruction memory shares rst_n, so no stale ack follows reset.

Structure
REQ-030 Shared package cpu_pkg SHALL hold the fetch_state_t enum, the NPC_SEQ/NPC_BR/NPC_J/NPC_JR encodings and the default reset vector.
REQ-031 No sub-module; the 4:1 next-PC mux SHALL be instantiated by the parent, outside this block.

Verification
REQ-032 Reset release, ack on the 2nd request cycle every fetch, if_ready=1 -> imem_addr 0x0, 0x4, 0x8; if_pc matches each address.
REQ-033 In VALID at if_pc=0x10, pulse jump with npc=0x200, if_ready=1 -> if_valid drops, npc_sel=2'b10, next imem_addr=0x200.
REQ-034 Pulse branch_taken in FETCH, ack 3 cycles later -> DRAIN entered, data discarded, next request at branch target with no if_valid.
REQ-035 jr and branch_taken asserted together -> npc_sel=2'b11; PC loads the register target.
REQ-036 RESET_VEC=32'hFFFF_FFFC, one sequential fetch -> pc_plus4=0x0, next imem_addr=0x0.
REQ-037 Assert rst_n low while imem_req=1 -> imem_req and if_valid go to 0 with no clock edge; after release, first imem_addr=RESET_VEC.

Source files
------------

// File: rtl/cpu_pkg.sv
// Shared CPU front-end definitions: fetch FSM states, next-PC select codes,
// default reset vector and an address-alignment helper.
package cpu_pkg;

  typedef enum logic [1:0] {
    BOOT  = 2'd0,
    FETCH = 2'd1,
    VALID = 2'd2,
    DRAIN = 2'd3
  } fetch_state_t;

  localparam logic [1:0] NPC_SEQ = 2'b00;
  localparam logic [1:0] NPC_BR  = 2'b01;
  localparam logic [1:0] NPC_J   = 2'b10;
  localparam logic [1:0] NPC_JR  = 2'b11;

  localparam logic [31:0] RESET_VEC_DEFAULT = 32'h0000_0000;

  function automatic logic [31:0] word_align(input logic [31:0] a);
    return a & 32'hFFFF_FFFC;
  endfunction

endpackage

// File: rtl/pc_fetch_ctrl_if.sv
// Fetch-side buses: instruction-memory request/ack and the fetch-to-decode
// valid/ready handshake. master = fetch controller, slave = memory + decode.
interface pc_fetch_ctrl_if;

  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack;
  logic [31:0] imem_rdata;
  logic        if_valid;
  logic [31:0] if_instr;
  logic [31:0] if_pc;
  logic        if_ready;

  modport master (
    output imem_req, imem_addr, if_valid, if_instr, if_pc,
    input  imem_ack, imem_rdata, if_ready
  );

  modport slave (
    input  imem_req, imem_addr, if_valid, if_instr, if_pc,
    output imem_ack, imem_rdata, if_ready
  );

endinterface

// File: rtl/pc_fetch_ctrl.sv
// PC register and instruction-fetch sequencer; the next-PC 4:1 mux lives in
// the parent and is steered through npc_sel.
//
// state | meaning
// BOOT  | one idle cycle after reset, no request
// FETCH | request outstanding at PC
// VALID | instruction held for decode
// DRAIN | redirected while a request was in flight; wait for its ack
module pc_fetch_ctrl
  import cpu_pkg::*;
#(
  parameter logic [31:0] RESET_VEC = RESET_VEC_DEFAULT
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               branch_taken,
  input  logic               jump,
  input  logic               jr,
  output logic [1:0]         npc_sel,
  output logic [31:0]        pc_plus4,
  input  logic [31:0]        npc,
  pc_fetch_ctrl_if.master    fif
);

  fetch_state_t state;
  logic [31:0]  pc;
  logic         redirect;

  assign redirect      = jr | jump | branch_taken;
  assign pc_plus4      = pc + 32'd4;
  assign fif.imem_addr = pc;

  always_comb begin
    npc_sel = NPC_SEQ;
    if (jr)                npc_sel = NPC_JR;
    else if (jump)         npc_sel = NPC_J;
    else if (branch_taken) npc_sel = NPC_BR;
  end

  // imem_req is registered alongside the state so it is high exactly in FETCH.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= BOOT;
      pc           <= RESET_VEC;
      fif.imem_req <= 1'b0;
      fif.if_valid <= 1'b0;
      fif.if_instr <= 32'h0;
      fif.if_pc    <= 32'h0;
    end else begin
      case (state)
        BOOT: begin
          state        <= FETCH;
          fif.imem_req <= 1'b1;
        end

        FETCH: begin
          if (fif.imem_ack && !redirect) begin
            fif.if_instr <= fif.imem_rdata;
            fif.if_pc    <= pc;
            fif.if_valid <= 1'b1;
            pc           <= word_align(npc);
            fif.imem_req <= 1'b0;
            state        <= VALID;
          end else if (fif.imem_ack) begin
            pc           <= word_align(npc);
          end else if (redirect) begin
            pc           <= word_align(npc);
            fif.imem_req <= 1'b0;
            state        <= DRAIN;
          end
        end

        DRAIN: begin
          if (redirect) pc <= word_align(npc);
          if (fif.imem_ack) begin
            fif.imem_req <= 1'b1;
            state        <= FETCH;
          end
        end

        VALID: begin
          if (redirect) begin
            pc           <= word_align(npc);
            fif.if_valid <= 1'b0;
            fif.imem_req <= 1'b1;
            state        <= FETCH;
          end else if (fif.if_ready) begin
            fif.if_valid <= 1'b0;
            fif.imem_req <= 1'b1;
            state        <= FETCH;
          end
        end

        default: begin
          state        <= BOOT;
          fif.imem_req <= 1'b0;
          fif.if_valid <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_pc_fetch_ctrl.sv
// Directed bench for pc_fetch_ctrl: sequential fetch, redirects in each state,
// select priority, PC wrap and asynchronous reset.
module tb_pc_fetch_ctrl;
  import cpu_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        branch_taken, jump, jr;
  logic [1:0]  npc_sel;
  logic [31:0] pc_plus4, npc;
  logic [31:0] br_tgt, j_tgt, jr_tgt;

  logic [1:0]  w_sel;
  logic [31:0] w_plus4;

  int n_chk = 0;
  int n_bad = 0;

  pc_fetch_ctrl_if fif ();
  pc_fetch_ctrl_if wif ();

  always #5 clk = ~clk;

  // external next-PC mux owned by the parent
  always_comb begin
    case (npc_sel)
      2'b00:   npc = pc_plus4;
      2'b01:   npc = br_tgt;
      2'b10:   npc = j_tgt;
      default: npc = jr_tgt;
    endcase
  end

  pc_fetch_ctrl dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .branch_taken (branch_taken),
    .jump         (jump),
    .jr           (jr),
    .npc_sel      (npc_sel),
    .pc_plus4     (pc_plus4),
    .npc          (npc),
    .fif          (fif.master)
  );

  pc_fetch_ctrl #(.RESET_VEC(32'hFFFF_FFFC)) dut_w (
    .clk          (clk),
    .rst_n        (rst_n),
    .branch_taken (1'b0),
    .jump         (1'b0),
    .jr           (1'b0),
    .npc_sel      (w_sel),
    .pc_plus4     (w_plus4),
    .npc          (w_plus4),
    .fif          (wif.master)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // from FETCH at address a: one wait cycle, ack on the 2nd request cycle, hold in VALID
  task automatic fetch_to_valid(input logic [31:0] a, input logic [31:0] instr);
    chk("req_fetch", {31'b0, fif.imem_req}, 32'd1);
    chk("addr_fetch", fif.imem_addr, a);
    @(negedge clk);
    chk("addr_hold", fif.imem_addr, a);
    chk("req_hold", {31'b0, fif.imem_req}, 32'd1);
    fif.imem_ack = 1'b1;
    fif.imem_rdata = instr;
    @(negedge clk);
    fif.imem_ack = 1'b0;
    chk("valid_set", {31'b0, fif.if_valid}, 32'd1);
    chk("if_instr", fif.if_instr, instr);
    chk("if_pc", fif.if_pc, a);
    chk("req_valid", {31'b0, fif.imem_req}, 32'd0);
    chk("pc_adv", fif.imem_addr, a + 32'd4);
    @(negedge clk);
    chk("valid_hold", {31'b0, fif.if_valid}, 32'd1);
    chk("instr_hold", fif.if_instr, instr);
  endtask

  task automatic fetch_ok(input logic [31:0] a, input logic [31:0] instr);
    fetch_to_valid(a, instr);
    fif.if_ready = 1'b1;
    @(negedge clk);
    fif.if_ready = 1'b0;
    chk("valid_clr", {31'b0, fif.if_valid}, 32'd0);
    chk("req_next", {31'b0, fif.imem_req}, 32'd1);
    chk("addr_next", fif.imem_addr, a + 32'd4);
  endtask

  initial begin
    rst_n = 1'b0;
    branch_taken = 1'b0; jump = 1'b0; jr = 1'b0;
    br_tgt = 32'h0; j_tgt = 32'h0; jr_tgt = 32'h0;
    fif.imem_ack = 1'b0; fif.imem_rdata = 32'h0; fif.if_ready = 1'b0;
    wif.imem_ack = 1'b0; wif.imem_rdata = 32'h0; wif.if_ready = 1'b1;
    repeat (2) @(negedge clk);

    chk("rst_req", {31'b0, fif.imem_req}, 32'd0);
    chk("rst_valid", {31'b0, fif.if_valid}, 32'd0);
    chk("rst_instr", fif.if_instr, 32'h0);
    chk("rst_ifpc", fif.if_pc, 32'h0);
    chk("rst_addr", fif.imem_addr, 32'h0);
    chk("rst_plus4", pc_plus4, 32'h4);
    chk("rst_w_addr", wif.imem_addr, 32'hFFFF_FFFC);
    chk("rst_w_plus4", w_plus4, 32'h0);

    rst_n = 1'b1;
    @(negedge clk);
    chk("boot_to_fetch", {31'b0, fif.imem_req}, 32'd1);
    chk("first_addr", fif.imem_addr, 32'h0);
    chk("w_first_addr", wif.imem_addr, 32'hFFFF_FFFC);
    wif.imem_ack = 1'b1;
    wif.imem_rdata = 32'hA5A5_0001;
    @(negedge clk);
    wif.imem_ack = 1'b0;
    chk("w_valid", {31'b0, wif.if_valid}, 32'd1);
    chk("w_ifpc", wif.if_pc, 32'hFFFF_FFFC);
    chk("w_wrap_addr", wif.imem_addr, 32'h0);
    @(negedge clk);
    chk("w_req_again", {31'b0, wif.imem_req}, 32'd1);
    chk("w_next_addr", wif.imem_addr, 32'h0);
    chk("noack_pc_held", fif.imem_addr, 32'h0);

    fetch_ok(32'h0, 32'h1000_0000);
    fetch_ok(32'h4, 32'h1000_0004);
    fetch_ok(32'h8, 32'h1000_0008);
    fetch_ok(32'hC, 32'h1000_000C);

    // jump from VALID flushes the held instruction
    fetch_to_valid(32'h10, 32'h1000_0010);
    jump = 1'b1; j_tgt = 32'h200; fif.if_ready = 1'b1;
    #1 chk("sel_jump", {30'b0, npc_sel}, 32'h2);
    @(negedge clk);
    jump = 1'b0; fif.if_ready = 1'b0;
    chk("flush_valid", {31'b0, fif.if_valid}, 32'd0);
    chk("flush_req", {31'b0, fif.imem_req}, 32'd1);
    chk("jump_addr", fif.imem_addr, 32'h200);

    // branch while a request is outstanding, ack arrives 3 cycles later
    branch_taken = 1'b1; br_tgt = 32'h300;
    #1 chk("sel_branch", {30'b0, npc_sel}, 32'h1);
    @(negedge clk);
    branch_taken = 1'b0;
    chk("drain_req", {31'b0, fif.imem_req}, 32'd0);
    chk("drain_addr", fif.imem_addr, 32'h300);
    jump = 1'b1; j_tgt = 32'h400;
    @(negedge clk);
    jump = 1'b0;
    chk("drain_latest", fif.imem_addr, 32'h400);
    @(negedge clk);
    chk("drain_wait", {31'b0, fif.imem_req}, 32'd0);
    fif.imem_ack = 1'b1; fif.imem_rdata = 32'hDEAD_BEEF;
    @(negedge clk);
    fif.imem_ack = 1'b0;
    chk("drain_no_valid", {31'b0, fif.if_valid}, 32'd0);
    chk("drain_refetch", {31'b0, fif.imem_req}, 32'd1);
    chk("drain_tgt", fif.imem_addr, 32'h400);

    // jr beats branch; target low bits forced to zero
    jr = 1'b1; branch_taken = 1'b1; jr_tgt = 32'h503; br_tgt = 32'h600;
    #1 chk("sel_jr", {30'b0, npc_sel}, 32'h3);
    @(negedge clk);
    jr = 1'b0; branch_taken = 1'b0;
    chk("jr_addr", fif.imem_addr, 32'h500);
    fif.imem_ack = 1'b1; fif.imem_rdata = 32'hDEAD_0002;
    @(negedge clk);
    fif.imem_ack = 1'b0;
    chk("jr_refetch", {31'b0, fif.imem_req}, 32'd1);
    chk("jr_no_valid", {31'b0, fif.if_valid}, 32'd0);

    // ack and redirect together: data dropped, new request at target
    fif.imem_ack = 1'b1; fif.imem_rdata = 32'h1111_1111;
    branch_taken = 1'b1; br_tgt = 32'h700;
    @(negedge clk);
    fif.imem_ack = 1'b0; branch_taken = 1'b0;
    chk("ackredir_req", {31'b0, fif.imem_req}, 32'd1);
    chk("ackredir_addr", fif.imem_addr, 32'h700);
    chk("ackredir_valid", {31'b0, fif.if_valid}, 32'd0);

    fetch_ok(32'h700, 32'hCAFE_0001);

    // asynchronous reset mid-request
    #2 rst_n = 1'b0;
    #1;
    chk("arst_req", {31'b0, fif.imem_req}, 32'd0);
    chk("arst_valid", {31'b0, fif.if_valid}, 32'd0);
    chk("arst_instr", fif.if_instr, 32'h0);
    chk("arst_addr", fif.imem_addr, 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("rerun_req", {31'b0, fif.imem_req}, 32'd1);
    chk("rerun_addr", fif.imem_addr, 32'h0);

    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end

endmodule
